matmul_stream_engine: RTL and testbench

Parametrised signed fixed-point matrix-multiply engine computing C = A×B (optionally C += A×B) for runtime dimensions M×K by K×N, up to compile-time maxima. Operands arrive over a single valid/ready input stream into internal buffers, and results leave row-major over a valid/ready output stream. The engine adds configurable data and accumulator widths, a transposed-B load mode and an accumulate-into-previous-result mode. It sits between the DMA/streaming front end and the result sink in the matrix datapath.

---
 rtl/matmul_stream_engine.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_matmul_stream_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_engine.sv
// matmul_stream_engine
// Signed fixed-point matrix multiply C = A x B (or C += A x B) for runtime
// dimensions M x K by K x N, up to the compile-time maxima.
// A and then B arrive over one valid/ready word stream. B can be sent as
// B[k][j] row-major or as B-transposed row-major. One MAC is performed per
// cycle, and C is emitted row-major over a valid/ready result stream.
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   cfg_m/k/n                 dimensions, sampled when start is accepted
//   cfg_transpose_b           B arrives as B-transposed (N x K row-major)
//   cfg_accumulate            seed each C element from the retained result
//   start / busy / done / err job control and status
//   in_valid/in_ready/in_data operand stream
//   out_valid/out_ready/out_data/out_last  result stream, last on C[M-1][N-1]
module matmul_stream_engine #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int MAX_M  = 16,
   parameter int MAX_K  = 16,
   parameter int MAX_N  = 16,
   parameter int DIM_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIM_W-1:0]  cfg_m,
   input  logic [DIM_W-1:0]  cfg_k,
   input  logic [DIM_W-1:0]  cfg_n,
   input  logic              cfg_transpose_b,
   input  logic              cfg_accumulate,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_last
);

   localparam int MW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
   localparam int KW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
   localparam int NW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_A  = 3'd1;
   localparam logic [2:0] S_LOAD_B  = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   // Operand and result buffers; they are deliberately never cleared.
   logic signed [DATA_W-1:0] a_mem [MAX_M][MAX_K];
   logic signed [DATA_W-1:0] b_mem [MAX_K][MAX_N];
   logic signed [ACC_W-1:0]  c_mem [MAX_M][MAX_N];

   logic [2:0]              state_q, state_d;
   logic [MW-1:0]           i_q, i_d;
   logic [NW-1:0]           j_q, j_d;
   logic [KW-1:0]           k_q, k_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    c_valid_q, c_valid_d;
   logic [MW-1:0]           prev_m_q, prev_m_d;
   logic [NW-1:0]           prev_n_q, prev_n_d;
   // Configuration, with each dimension stored as its last index (dim - 1).
   logic [MW-1:0]           m_last_q;
   logic [KW-1:0]           k_last_q;
   logic [NW-1:0]           n_last_q;
   logic                    transpose_q;
   logic                    acc_eff_q;
   logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [ACC_W-1:0]        out_data_q, out_data_d;

   logic                    dims_bad_s, in_fire_s, out_fire_s;
   logic                    a_we_s, b_we_s, c_we_s;
   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [ACC_W-1:0]    base_s, sum_s;

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

   assign dims_bad_s = (cfg_m == {DIM_W{1'b0}}) || (cfg_m > DIM_W'(MAX_M)) ||
                       (cfg_k == {DIM_W{1'b0}}) || (cfg_k > DIM_W'(MAX_K)) ||
                       (cfg_n == {DIM_W{1'b0}}) || (cfg_n > DIM_W'(MAX_N));
   assign in_fire_s  = in_valid && in_ready_q;
   assign out_fire_s = out_valid_q && out_ready;

   // MAC datapath: the first k of each (i,j) restarts from the seed value.
   assign prod_s = a_mem[i_q][k_q] * b_mem[k_q][j_q];
   assign base_s = (k_q != {KW{1'b0}}) ? acc_q :
                   (acc_eff_q ? c_mem[i_q][j_q] : {ACC_W{1'b0}});
   assign sum_s  = base_s + ACC_W'(prod_s);

   // Next-state logic: sequencing of i/j/k through load, compute and drain.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      acc_d     = acc_q;
      a_we_s    = 1'b0;
      b_we_s    = 1'b0;
      c_we_s    = 1'b0;
      c_valid_d = c_valid_q;
      prev_m_d  = prev_m_q;
      prev_n_d  = prev_n_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               i_d     = {MW{1'b0}};
               j_d     = {NW{1'b0}};
               k_d     = {KW{1'b0}};
               state_d = dims_bad_s ? S_FINISH : S_LOAD_A;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD_A: begin
            if (in_fire_s) begin
               a_we_s = 1'b1;
               if (k_q == k_last_q) begin
                  k_d = {KW{1'b0}};
                  if (i_q == m_last_q) begin
                     i_d     = {MW{1'b0}};
                     state_d = S_LOAD_B;
                  end else begin
                     i_d = i_q + MW'(1);
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else begin
               a_we_s = 1'b0;
            end
         end
         S_LOAD_B: begin
            // j/k always address logical B[k][j]; only the walk order changes.
            if (in_fire_s) begin
               b_we_s = 1'b1;
               if (!transpose_q) begin
                  if (j_q == n_last_q) begin
                     j_d = {NW{1'b0}};
                     if (k_q == k_last_q) begin
                        k_d     = {KW{1'b0}};
                        state_d = S_COMPUTE;
                     end else begin
                        k_d = k_q + KW'(1);
                     end
                  end else begin
                     j_d = j_q + NW'(1);
                  end
               end else begin
                  if (k_q == k_last_q) begin
                     k_d = {KW{1'b0}};
                     if (j_q == n_last_q) begin
                        j_d     = {NW{1'b0}};
                        state_d = S_COMPUTE;
                     end else begin
                        j_d = j_q + NW'(1);
                     end
                  end else begin
                     k_d = k_q + KW'(1);
                  end
               end
            end else begin
               b_we_s = 1'b0;
            end
         end
         S_COMPUTE: begin
            acc_d = sum_s;
            if (k_q == k_last_q) begin
               k_d    = {KW{1'b0}};
               c_we_s = 1'b1;
               if (j_q == n_last_q) begin
                  j_d = {NW{1'b0}};
                  if (i_q == m_last_q) begin
                     i_d     = {MW{1'b0}};
                     state_d = S_DRAIN;
                  end else begin
                     i_d = i_q + MW'(1);
                  end
               end else begin
                  j_d = j_q + NW'(1);
               end
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DRAIN: begin
            if (out_fire_s) begin
               if (j_q == n_last_q) begin
                  j_d = {NW{1'b0}};
                  if (i_q == m_last_q) begin
                     i_d       = {MW{1'b0}};
                     state_d   = S_FINISH;
                     c_valid_d = 1'b1;
                     prev_m_d  = m_last_q;
                     prev_n_d  = n_last_q;
                  end else begin
                     i_d = i_q + MW'(1);
                  end
               end else begin
                  j_d = j_q + NW'(1);
               end
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they align with it.
      busy_d      = (state_d == S_LOAD_A) || (state_d == S_LOAD_B) ||
                    (state_d == S_COMPUTE) || (state_d == S_DRAIN);
      in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      done_d      = (state_d == S_FINISH);
      // A rejected job is the only path that reaches FINISH directly from IDLE.
      err_d       = (state_d == S_FINISH) && (state_q == S_IDLE);
      out_valid_d = (state_d == S_DRAIN);
      out_last_d  = (state_d == S_DRAIN) && (i_d == m_last_q) && (j_d == n_last_q);
      if (state_d == S_DRAIN) begin
         // When M=N=1, the entry into DRAIN reads the element being written now.
         if (c_we_s && (i_d == i_q) && (j_d == j_q)) begin
            out_data_d = sum_s;
         end else begin
            out_data_d = c_mem[i_d][j_d];
         end
      end else begin
         out_data_d = {ACC_W{1'b0}};
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= {MW{1'b0}};
         j_q         <= {NW{1'b0}};
         k_q         <= {KW{1'b0}};
         acc_q       <= {ACC_W{1'b0}};
         c_valid_q   <= 1'b0;
         prev_m_q    <= {MW{1'b0}};
         prev_n_q    <= {NW{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= {ACC_W{1'b0}};
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         c_valid_q   <= c_valid_d;
         prev_m_q    <= prev_m_d;
         prev_n_q    <= prev_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // Job configuration, captured when start is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_last_q    <= {MW{1'b0}};
         k_last_q    <= {KW{1'b0}};
         n_last_q    <= {NW{1'b0}};
         transpose_q <= 1'b0;
         acc_eff_q   <= 1'b0;
      end else if ((state_q == S_IDLE) && start) begin
         m_last_q    <= MW'(cfg_m - DIM_W'(1));
         k_last_q    <= KW'(cfg_k - DIM_W'(1));
         n_last_q    <= NW'(cfg_n - DIM_W'(1));
         transpose_q <= cfg_transpose_b;
         // Accumulate applies only on top of a completed job with the same M and N.
         acc_eff_q   <= cfg_accumulate && c_valid_q &&
                        (MW'(cfg_m - DIM_W'(1)) == prev_m_q) &&
                        (NW'(cfg_n - DIM_W'(1)) == prev_n_q);
      end
   end

   // Buffer writes; enables are qualified by state, so reset blocks them.
   always_ff @(posedge clk) begin
      if (a_we_s) a_mem[i_q][k_q] <= in_data;
      if (b_we_s) b_mem[k_q][j_q] <= in_data;
      if (c_we_s) c_mem[i_q][j_q] <= sum_s;
   end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Self-checking bench for matmul_stream_engine. A matrix-level reference
// model predicts every result word. One compare process checks each output
// handshake and the hold behaviour while the output is stalled.
module tb_matmul_stream_engine;
   localparam int DW = 16, AW = 32, MM = 8, MK = 4, MN = 16, DIMW = 8;

   logic clk = 1'b0, rst = 1'b0;
   logic [DIMW-1:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
   logic cfg_transpose_b = 1'b0, cfg_accumulate = 1'b0, start = 1'b0;
   logic busy, done, err, in_ready, out_valid, out_last;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic [AW-1:0] out_data;

   matmul_stream_engine #(.DATA_W(DW), .ACC_W(AW), .MAX_M(MM), .MAX_K(MK),
                          .MAX_N(MN), .DIM_W(DIMW)) u_dut (
      .clk(clk), .rst(rst), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
      .cfg_transpose_b(cfg_transpose_b), .cfg_accumulate(cfg_accumulate),
      .start(start), .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last));

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_fail = 0;
   int a_m[MM][MK];
   int b_m[MK][MN];          // logical B[k][j]
   int mdl_c[MM][MN];        // retained result of the last completed job
   bit mdl_cv = 1'b0;
   int mdl_m = 0, mdl_n = 0;
   logic [AW:0] exp_q[$];    // {last, data}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic int r16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < MM; i++) for (int k = 0; k < MK; k++) a_m[i][k] = r16();
      for (int k = 0; k < MK; k++) for (int j = 0; j < MN; j++) b_m[k][j] = r16();
   endtask

   task automatic set_basic();
      a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
      b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
   endtask

   // Compare process: one check per output handshake, plus hold checks while stalled.
   initial begin
      logic [AW:0] prev_word, e;
      bit prev_hold;
      prev_hold = 1'b0;
      prev_word = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (out_valid && prev_hold) check("stall_hold", {out_last, out_data}, prev_word);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL extra_word: got %0h, expected no word", {out_last, out_data});
               end else begin
                  e = exp_q.pop_front();
                  check("out_word", {out_last, out_data}, e);
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_last, out_data};
         end
      end
   end

   task automatic run_job(input int m, k, n, input bit tr, acc, input int gap_pct, input bit stall);
      bit rej, eff, busy_ok;
      int c_new[MM][MN];
      int words[$];
      int s, idx, guard, hs, stall_left, t0;
      rej = (m == 0) || (m > MM) || (k == 0) || (k > MK) || (n == 0) || (n > MN);
      eff = acc && mdl_cv && (m == mdl_m) && (n == mdl_n);
      if (!rej) begin
         for (int i = 0; i < m; i++) for (int j = 0; j < n; j++) begin
            s = eff ? mdl_c[i][j] : 0;
            for (int kk = 0; kk < k; kk++) s += a_m[i][kk] * b_m[kk][j];
            c_new[i][j] = s;
            exp_q.push_back({(i == m - 1) && (j == n - 1), s});
         end
         for (int i = 0; i < m; i++) for (int kk = 0; kk < k; kk++) words.push_back(a_m[i][kk]);
         if (!tr) begin
            for (int kk = 0; kk < k; kk++) for (int j = 0; j < n; j++) words.push_back(b_m[kk][j]);
         end else begin
            for (int j = 0; j < n; j++) for (int kk = 0; kk < k; kk++) words.push_back(b_m[kk][j]);
         end
      end
      @(negedge clk);
      cfg_m = DIMW'(m); cfg_k = DIMW'(k); cfg_n = DIMW'(n);
      cfg_transpose_b = tr; cfg_accumulate = acc; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      if (rej) begin
         check("reject_pulse", {done, err, busy, in_ready}, 4'b1100);
         @(negedge clk);
         check("reject_after", {done, err, busy, in_ready}, 4'b0000);
         return;
      end
      idx = 0; guard = 0; busy_ok = 1'b1;
      while (idx < words.size() && guard < 20000) begin
         busy_ok &= busy;
         if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data = DW'(words[idx]);
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
      check("words_accepted", idx, words.size());
      hs = 0; guard = 0; stall_left = stall ? 3 : 0;
      while (!done && guard < 20000) begin
         busy_ok &= busy;
         check("in_ready_low", in_ready, 1'b0);
         if (out_valid && hs == (m * n) / 2 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) hs++;
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b1;
      check("done_status", {done, err, busy}, 3'b100);
      check("busy_during_job", busy_ok, 1'b1);
      check("handshakes", hs, m * n);
      // Counting the start cycle and the done cycle both, latency is 1+MK+KN+MNK+MN+1.
      if (gap_pct == 0 && !stall)
         check("latency", cyc - t0 + 2, 1 + m * k + k * n + m * n * k + m * n + 1);
      @(negedge clk);
      check("done_one_cycle", {done, busy}, 2'b00);
      check("queue_drained", exp_q.size(), 0);
      for (int i = 0; i < m; i++) for (int j = 0; j < n; j++) mdl_c[i][j] = c_new[i][j];
      mdl_cv = 1'b1; mdl_m = m; mdl_n = n;
   endtask

   initial begin
      logic [31:0] w;
      int m, k, n;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_values", {busy, done, err, in_ready, out_valid, out_last, out_data}, '0);
      rst = 1'b0;
      @(negedge clk);

      // Rejected jobs: K=0 and M above its maximum.
      run_job(2, 0, 2, 1'b0, 1'b0, 0, 1'b0);
      run_job(MM + 1, 1, 1, 1'b0, 1'b0, 0, 1'b0);

      set_basic();
      run_job(2, 2, 2, 1'b0, 1'b0, 0, 1'b0);
      check("pin_basic00", mdl_c[0][0], 19);
      check("pin_basic01", mdl_c[0][1], 22);
      check("pin_basic10", mdl_c[1][0], 43);
      check("pin_basic11", mdl_c[1][1], 50);
      run_job(2, 2, 2, 1'b1, 1'b0, 0, 1'b0);
      run_job(2, 2, 2, 1'b0, 1'b1, 0, 1'b0);
      check("pin_acc00", mdl_c[0][0], 38);
      check("pin_acc11", mdl_c[1][1], 100);
      run_job(1, 2, 2, 1'b0, 1'b1, 0, 1'b0);
      check("pin_dimchg01", mdl_c[0][1], 22);

      // Wrap-around: two products of 2^30 give 2^31, which wraps in 32 bits.
      a_m[0][0] = -32768; a_m[0][1] = -32768; b_m[0][0] = -32768; b_m[1][0] = -32768;
      run_job(1, 2, 1, 1'b0, 1'b0, 0, 1'b0);
      w = mdl_c[0][0];
      check("pin_wrap", w, 32'h8000_0000);

      // Reset during LOAD_B: 4 A words and 2 B words, then reset.
      @(negedge clk);
      cfg_m = 8'd2; cfg_k = 8'd2; cfg_n = 8'd2; cfg_transpose_b = 1'b0;
      cfg_accumulate = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data = DW'(i + 1);
         @(negedge clk);
      end
      check("mid_load_b", {busy, in_ready, done}, 3'b110);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("reset_mid_job", {busy, done, err, in_ready, out_valid, out_last, out_data}, '0);
      @(negedge clk);
      rst = 1'b0;
      mdl_cv = 1'b0;
      @(negedge clk);
      check("no_done_after_reset", {done, busy}, 2'b00);
      set_basic();
      run_job(2, 2, 2, 1'b0, 1'b1, 0, 1'b0);
      check("pin_after_reset", mdl_c[1][1], 50);

      // Full-size job.
      fill_rand();
      run_job(MM, MK, MN, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);

      // Random jobs with input gaps and a drain stall; dims sometimes repeat so accumulate applies.
      for (int t = 0; t < 10; t++) begin
         fill_rand();
         m = $urandom_range(1, MM); k = $urandom_range(1, MK); n = $urandom_range(1, MN);
         if ($urandom_range(0, 1) == 1 && mdl_cv) begin
            m = mdl_m; n = mdl_n;
         end
         run_job(m, k, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
